// File: rtl/csa_mul_sequencer_pkg.sv
// Shared multiply/divide unit definitions: multiplier FSM encoding and the
// iteration counter width helper.
package mdu_pkg;

    typedef logic [1:0] mul_state_t;

    localparam mul_state_t IDLE    = 2'd0;
    localparam mul_state_t ACCUM   = 2'd1;
    localparam mul_state_t RESOLVE = 2'd2;
    localparam mul_state_t DONE    = 2'd3;

    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/csa_mul_sequencer_if.sv
// Operand issue / result writeback handshake bundle for the sequential multiplier.
interface csa_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 abort;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, multiplicand, multiplier, abort, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, abort, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/csa_mul_sequencer_csa.sv
// Bitwise 3:2 carry-save adder; carry_o carries twice the weight of sum_o.
module carrySaveAdder #(
    parameter int width = 32
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic [width-1:0] c_i,
    output logic [width-1:0] sum_o,
    output logic [width-1:0] carry_o
);
    assign sum_o   = a_i ^ b_i ^ c_i;
    assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/csa_mul_sequencer.sv
// Sequential unsigned multiplier: one multiplier bit per cycle into a carry-save
// accumulator, upper half resolved by a single carry-propagate add.
module csa_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    csa_mul_sequencer_if.slave  bus
);
    import mdu_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH-1:0]   csa_s;
    logic [WIDTH-1:0]   csa_c;
    logic [WIDTH:0]     high_sum;
    logic               unused_resolve_cout;

    assign pp = b_q[0] ? a_q : '0;

    carrySaveAdder #(
        .width (WIDTH)
    ) u_csa (
        .a_i     (s_q),
        .b_i     (c_q),
        .c_i     (pp),
        .sum_o   (csa_s),
        .carry_o (csa_c)
    );

    // S and C are kept at equal weight, so the upper half is their plain sum.
    assign high_sum            = {1'b0, s_q} + {1'b0, c_q};
    assign unused_resolve_cout = high_sum[WIDTH];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        low_d     = low_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.multiplicand;
                    b_d     = bus.multiplier;
                    s_d     = '0;
                    c_d     = '0;
                    low_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    // Retire s'[0] into the low half; c' already sits one bit up.
                    s_d   = {1'b0, csa_s[WIDTH-1:1]};
                    c_d   = csa_c;
                    low_d = {csa_s[0], low_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = RESOLVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESOLVE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    product_d = {high_sum[WIDTH-1:0], low_q};
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= '0;
            low_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            c_q       <= c_d;
            low_q     <= low_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == ACCUM) || (state_q == RESOLVE);
    assign bus.product   = product_q;

endmodule

// File: tb/tb_csa_mul_sequencer.sv
// Scoreboard bench for csa_mul_sequencer: directed vectors plus a random regression.
module tb_csa_mul_sequencer;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    logic [2*W-1:0] exp_q[$];

    csa_mul_sequencer_if #(.WIDTH(W)) bus ();

    csa_mul_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", bus.product, '0);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                check("product", bus.product, e);
            end
        end
        if (!rst && dut.state_q == RESOLVE)
            check("resolve_cout", {{(2*W-1){1'b0}}, dut.unused_resolve_cout}, '0);
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input bit push, output int waits);
        bit ok;
        bit rdy;
        ok    = 1'b0;
        waits = 0;
        bus.in_valid     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        while (!ok && waits < 200) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
            else waits++;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 1, 0);
        else if (push) exp_q.push_back(exp);
    endtask

    initial begin
        int waits;
        int n;
        int busy_cnt;
        int ov_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        total = 0;
        passed = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 1);
        check("rst_out_valid", 64'(bus.out_valid), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_product", bus.product, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 7*6, latency and busy duration
        do_op(32'd7, 32'd6, 64'd42, 1'b1, waits);
        check("first_accept_waits", 64'(waits), 0);
        n = 0;
        busy_cnt = 0;
        while (!bus.out_valid && n < 100) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 33);
        check("busy_cycles", 64'(busy_cnt), 33);

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, waits);

        // back-to-back: in_valid held while busy, in_ready low for ACCUM+RESOLVE+DONE
        do_op(32'd0, 32'h1234_5678, 64'd0, 1'b1, waits);
        do_op(32'h8000_0000, 32'd2, 64'h1_0000_0000, 1'b1, waits);
        check("b2b_ready_low_1", 64'(waits), 34);
        do_op(32'd3, 32'd5, 64'd15, 1'b1, waits);
        check("b2b_ready_low_2", 64'(waits), 34);

        // stall with out_ready low; new operands offered, abort in DONE ignored
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.multiplicand = 32'd2;
        bus.multiplier = 32'd2;
        for (int i = 0; i < 10; i++) begin
            check("stall_out_valid", 64'(bus.out_valid), 1);
            check("stall_product", bus.product, 64'd15);
            check("stall_in_ready", 64'(bus.in_ready), 0);
            bus.abort = (i == 5);
            @(posedge clk); #1;
        end
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
        do_op(32'd2, 32'd2, 64'd4, 1'b1, waits);

        // abort in ACCUM cycle 10
        do_op(32'd100, 32'd200, 64'd20000, 1'b0, waits);
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_in_ready", 64'(bus.in_ready), 1);
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_out_valid", 64'(bus.out_valid), 0);
        ov_cnt = 0;
        repeat (40) begin
            if (bus.out_valid) ov_cnt++;
            @(posedge clk); #1;
        end
        check("abort_no_output", 64'(ov_cnt), 0);
        do_op(32'd9, 32'd9, 64'd81, 1'b1, waits);

        // reset mid-ACCUM discards the operation
        do_op(32'd5, 32'd5, 64'd25, 1'b0, waits);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(bus.in_ready), 1);
        check("midrst_out_valid", 64'(bus.out_valid), 0);
        check("midrst_product", bus.product, 0);
        check("midrst_busy", 64'(bus.busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(ra, rb, {{W{1'b0}}, ra} * {{W{1'b0}}, rb}, 1'b1, waits);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
